// File: rtl/imem_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words and writes
// them to consecutive word-aligned instruction memory addresses, holding the core in reset until done.
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W:0]   LoadLen,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic              ImemWrEn,
    output logic [63:0]       ImemWrAddr,
    output logic [31:0]       ImemWrData,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic              CoreHold
);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    state_t          state_next;
    logic [ADDR_W:0] word_idx;
    logic [ADDR_W:0] word_idx_inc;
    logic [ADDR_W:0] load_len;
    logic [1:0]      byte_cnt;
    logic [31:0]     word_buf;
    logic            start_seen;
    logic            start_ok;
    logic            byte_fire;

    // word_idx carries one extra bit so a full-depth load reaches DEPTH without wrapping
    assign word_idx_inc = word_idx + ONE;
    assign start_seen   = Start && (state == IDLE || state == DONE || state == ERR);
    assign start_ok     = (LoadLen != '0) && (LoadLen <= DEPTH);
    assign byte_fire    = ByteValid && (state == RECV);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (Start) begin
                    state_next = start_ok ? RECV : ERR;
                end
            end
            RECV: begin
                if (ByteValid && byte_cnt == 2'd3) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = (word_idx_inc == load_len) ? DONE : RECV;
            end
            default: state_next = IDLE;
        endcase
    end

    // A reset mid-word simply drops the partial word; memory already written is untouched
    always_ff @(posedge Clock) begin
        if (Reset) begin
            word_idx <= '0;
            load_len <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
        end else begin
            if (start_seen && start_ok) begin
                load_len <= LoadLen;
                word_idx <= '0;
                byte_cnt <= '0;
            end
            if (byte_fire) begin
                word_buf[{byte_cnt, 3'b000} +: 8] <= ByteIn;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == WRITE) begin
                word_idx <= word_idx_inc;
            end
        end
    end

    assign ByteReady  = (state == RECV);
    assign ImemWrEn   = (state == WRITE);
    assign ImemWrAddr = (state == WRITE) ? {{(61 - ADDR_W){1'b0}}, word_idx, 2'b00} : 64'd0;
    assign ImemWrData = (state == WRITE) ? word_buf : 32'd0;
    assign Busy       = (state == RECV) || (state == WRITE);
    assign Done       = (state == DONE);
    assign Error      = (state == ERR);
    assign CoreHold   = (state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are derived from the byte image
// when a load is issued, and a negedge monitor compares every write strobe against them.
module tb_imem_loader;

    localparam int ADDR_W = 6;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic [ADDR_W:0]   LoadLen = '0;
    logic [7:0]        ByteIn = '0;
    logic              ByteValid = 1'b0;
    logic              ByteReady;
    logic              ImemWrEn;
    logic [63:0]       ImemWrAddr;
    logic [31:0]       ImemWrData;
    logic              Busy;
    logic              Done;
    logic              Error;
    logic              CoreHold;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          last_wr_cycle = -10;
    logic [63:0] last_addr = '0;
    logic [7:0]  tx[$];
    wr_t         exp_q[$];
    wr_t         got;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .Clock(clk), .Reset(Reset), .Start(Start), .LoadLen(LoadLen),
        .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
        .ImemWrEn(ImemWrEn), .ImemWrAddr(ImemWrAddr), .ImemWrData(ImemWrData),
        .Busy(Busy), .Done(Done), .Error(Error), .CoreHold(CoreHold)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected writes come straight from the image: word w lives at byte address 4*w, little-endian
    function automatic void model_load(input int len);
        wr_t e;
        for (int w = 0; w < len; w++) begin
            e.addr = 64'(w * 4);
            e.data = {tx[4*w+3], tx[4*w+2], tx[4*w+1], tx[4*w]};
            exp_q.push_back(e);
        end
    endfunction

    function automatic void fill_random(input int n);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
    endfunction

    always @(negedge clk) begin
        if (ImemWrEn) begin
            wr_count++;
            last_wr_cycle = cyc;
            last_addr = ImemWrAddr;
            check_output("ready_in_write", 64'(ByteReady), 64'd0);
            if (exp_q.size() == 0) begin
                check_output("unexpected_write", ImemWrAddr, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                got = exp_q.pop_front();
                check_output("wr_addr", ImemWrAddr, got.addr);
                check_output("wr_data", 64'(ImemWrData), 64'(got.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int len);
        Start = 1'b1;
        LoadLen = (ADDR_W + 1)'(len);
        step();
        Start = 1'b0;
    endtask

    // mode 0: valid held high, 1: valid toggles every cycle, 2: random valid
    task automatic apply_stimulus(input int n, input int mode);
        int idx = 0;
        int budget = 0;
        bit phase = 1'b1;
        while (idx < n && budget < 4000) begin
            ByteIn = tx[idx];
            case (mode)
                0:       ByteValid = 1'b1;
                1:       ByteValid = phase;
                default: ByteValid = ($urandom_range(3) != 0);
            endcase
            phase = !phase;
            @(negedge clk);
            if (ByteValid && ByteReady) idx++;
            step();
            budget++;
        end
        ByteValid = 1'b0;
        if (idx < n) check_output("stream_timeout", 64'(idx), 64'(n));
    endtask

    task automatic wait_done(input string tag);
        int budget = 0;
        @(negedge clk);
        while (!Done && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check_output({tag, "_done"}, 64'(Done), 64'd1);
        check_output({tag, "_done_latency"}, 64'(cyc - last_wr_cycle), 64'd1);
        check_output({tag, "_corehold"}, 64'(CoreHold), 64'd0);
        check_output({tag, "_busy"}, 64'(Busy), 64'd0);
        step();
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check_output({tag, "_ready"}, 64'(ByteReady), 64'd0);
        check_output({tag, "_wren"}, 64'(ImemWrEn), 64'd0);
        check_output({tag, "_addr"}, ImemWrAddr, 64'd0);
        check_output({tag, "_data"}, 64'(ImemWrData), 64'd0);
        check_output({tag, "_busy"}, 64'(Busy), 64'd0);
        check_output({tag, "_done"}, 64'(Done), 64'd0);
        check_output({tag, "_error"}, 64'(Error), 64'd0);
        check_output({tag, "_corehold"}, 64'(CoreHold), 64'd1);
        step();
    endtask

    initial begin
        int wr0;

        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        check_reset_values("reset");

        $display("[TB] two-word load, valid held high");
        tx = {8'h20, 8'h00, 8'h80, 8'hD2, 8'h01, 8'h00, 8'h00, 8'h91};
        model_load(2);
        pulse_start(2);
        @(negedge clk);
        check_output("ready_after_start", 64'(ByteReady), 64'd1);
        check_output("busy_after_start", 64'(Busy), 64'd1);
        step();
        apply_stimulus(8, 0);
        wait_done("load2");

        $display("[TB] same load with toggling valid, restarted from DONE");
        model_load(2);
        pulse_start(2);
        apply_stimulus(8, 1);
        wait_done("toggle");

        $display("[TB] illegal lengths");
        pulse_start(0);
        @(negedge clk);
        check_output("len0_error", 64'(Error), 64'd1);
        check_output("len0_corehold", 64'(CoreHold), 64'd1);
        check_output("len0_ready", 64'(ByteReady), 64'd0);
        step();
        wr0 = wr_count;
        ByteValid = 1'b1;
        repeat (6) step();
        ByteValid = 1'b0;
        check_output("err_no_writes", 64'(wr_count - wr0), 64'd0);
        pulse_start(65);
        @(negedge clk);
        check_output("len65_error", 64'(Error), 64'd1);
        check_output("len65_ready", 64'(ByteReady), 64'd0);
        step();
        fill_random(4);
        model_load(1);
        pulse_start(1);
        @(negedge clk);
        check_output("recover_error", 64'(Error), 64'd0);
        check_output("recover_ready", 64'(ByteReady), 64'd1);
        step();
        apply_stimulus(4, 0);
        wait_done("recover");

        $display("[TB] full-depth load with random valid");
        fill_random(256);
        model_load(64);
        wr0 = wr_count;
        pulse_start(64);
        apply_stimulus(256, 2);
        wait_done("full");
        check_output("full_write_count", 64'(wr_count - wr0), 64'd64);
        check_output("full_last_addr", last_addr, 64'hFC);

        $display("[TB] reset after six bytes");
        fill_random(8);
        model_load(1);
        wr0 = wr_count;
        pulse_start(2);
        apply_stimulus(6, 0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_reset_values("midreset");
        repeat (8) step();
        check_output("midreset_writes", 64'(wr_count - wr0), 64'd1);
        fill_random(4);
        model_load(1);
        pulse_start(1);
        apply_stimulus(4, 0);
        wait_done("reload");

        $display("[TB] restart from DONE with ignored Start during RECV");
        fill_random(4);
        model_load(1);
        pulse_start(1);
        @(negedge clk);
        check_output("restart_corehold", 64'(CoreHold), 64'd1);
        check_output("restart_done", 64'(Done), 64'd0);
        step();
        pulse_start(3);
        apply_stimulus(4, 0);
        wait_done("restart");

        repeat (4) step();
        check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
